// File: rtl/triangle_scheduler.sv
// triangle_scheduler: walks the triangle BRAM for one frame, runs each triangle through the projector and forwards valid results.
module triangle_scheduler #(
   parameter int COORD_WIDTH = 32,
   parameter int IDX_WIDTH   = 12,
   parameter int MEM_LATENCY = 2
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      frame_start,
   input  logic [IDX_WIDTH-1:0]      num_tris,
   output logic [IDX_WIDTH-1:0]      tri_addr,
   input  logic [9*COORD_WIDTH-1:0]  tri_rd_data,
   output logic [9*COORD_WIDTH-1:0]  proj_verts_in,
   output logic                      proj_start,
   input  logic                      proj_busy,
   input  logic                      proj_done,
   input  logic                      proj_valid,
   input  logic [1:0]                proj_status,
   input  logic [12*COORD_WIDTH-1:0] proj_verts_out,
   output logic [12*COORD_WIDTH-1:0] out_tri,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      frame_done,
   output logic [IDX_WIDTH-1:0]      tris_drawn,
   output logic [IDX_WIDTH-1:0]      tris_culled,
   output logic [IDX_WIDTH-1:0]      tris_err
);
   localparam int LW = $clog2(MEM_LATENCY + 1);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ARM, S_WAIT, S_EMIT, S_NEXT, S_FINISH} state_t;
   state_t state_q, state_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d, num_q, num_d, drawn_q, drawn_d, culled_q, culled_d, err_q, err_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic skip_q, skip_d, start_q, start_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
   logic [9*COORD_WIDTH-1:0] verts_q, verts_d;
   logic [12*COORD_WIDTH-1:0] tri_q, tri_d;

   function automatic logic [IDX_WIDTH-1:0] sat_inc(input logic [IDX_WIDTH-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction

   assign tri_addr      = idx_q;
   assign proj_verts_in = verts_q;
   assign proj_start    = start_q;
   assign out_tri       = tri_q;
   assign out_valid     = valid_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;
   assign tris_drawn    = drawn_q;
   assign tris_culled   = culled_q;
   assign tris_err      = err_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      num_d    = num_q;
      cnt_d    = cnt_q;
      skip_d   = 1'b0;
      start_d  = 1'b0;
      verts_d  = verts_q;
      tri_d    = tri_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      drawn_d  = drawn_q;
      culled_d = culled_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: if (frame_start) begin
            num_d    = num_tris;
            idx_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            drawn_d  = '0;
            culled_d = '0;
            err_d    = '0;
            state_d  = (num_tris == '0) ? S_FINISH : S_FETCH;
         end
         // the read data is registered one edge after the BRAM output settles
         S_FETCH: if (cnt_q == LW'(MEM_LATENCY)) begin
            verts_d = tri_rd_data;
            state_d = S_ARM;
         end else cnt_d = cnt_q + 1'b1;
         S_ARM: if (!proj_busy && !proj_done) begin
            start_d = 1'b1;
            skip_d  = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: if (!skip_q && proj_done) begin
            if (proj_valid) begin
               tri_d   = proj_verts_out;
               valid_d = 1'b1;
               state_d = S_EMIT;
            end else begin
               culled_d = (proj_status == 2'd1) ? sat_inc(culled_q) : culled_q;
               err_d    = (proj_status == 2'd1) ? err_q : sat_inc(err_q);
               state_d  = S_NEXT;
            end
         end
         S_EMIT: if (out_ready) begin
            valid_d = 1'b0;
            drawn_d = sat_inc(drawn_q);
            state_d = S_NEXT;
         end
         S_NEXT: begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            state_d = (idx_d == num_q) ? S_FINISH : S_FETCH;
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         num_q    <= '0;
         cnt_q    <= '0;
         skip_q   <= 1'b0;
         start_q  <= 1'b0;
         verts_q  <= '0;
         tri_q    <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         drawn_q  <= '0;
         culled_q <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         num_q    <= num_d;
         cnt_q    <= cnt_d;
         skip_q   <= skip_d;
         start_q  <= start_d;
         verts_q  <= verts_d;
         tri_q    <= tri_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         drawn_q  <= drawn_d;
         culled_q <= culled_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_triangle_scheduler.sv
// tb_triangle_scheduler: randomized frames against a BRAM/projector model and a per-frame expected-result model.
module tb_triangle_scheduler;
   localparam int CW = 32;
   localparam int IW = 12;
   localparam int ML = 2;
   localparam int VW = 9 * CW;
   localparam int PW = 12 * CW;

   logic clk_in = 1'b0, rst_in = 1'b1, frame_start = 1'b0, out_ready = 1'b1;
   logic [IW-1:0] num_tris = '0;
   logic [IW-1:0] tri_addr, tris_drawn, tris_culled, tris_err;
   logic [VW-1:0] tri_rd_data, proj_verts_in;
   logic proj_start, proj_busy, proj_done, proj_valid, out_valid, busy, frame_done;
   logic [1:0] proj_status;
   logic [PW-1:0] proj_verts_out, out_tri;

   logic [VW-1:0] mem [64];
   logic [VW-1:0] pipe [ML];
   logic [VW-1:0] pv = '0;
   int lt [64];
   int st_a [64];
   bit vl [64];
   int dh = 1, bh = 0, t = 0;
   logic [PW-1:0] exp_q [$];
   logic [PW-1:0] got_q [$];
   int sidx_q [$];
   int exp_d, exp_c, exp_e;
   int n_start = 0, n_done = 0, n_cmp = 0, n_fail = 0;

   triangle_scheduler #(.COORD_WIDTH(CW), .IDX_WIDTH(IW), .MEM_LATENCY(ML)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start), .num_tris(num_tris),
      .tri_addr(tri_addr), .tri_rd_data(tri_rd_data), .proj_verts_in(proj_verts_in),
      .proj_start(proj_start), .proj_busy(proj_busy), .proj_done(proj_done),
      .proj_valid(proj_valid), .proj_status(proj_status), .proj_verts_out(proj_verts_out),
      .out_tri(out_tri), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .frame_done(frame_done), .tris_drawn(tris_drawn), .tris_culled(tris_culled), .tris_err(tris_err)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      pipe[0] <= mem[tri_addr[5:0]];
      for (int k = 1; k < ML; k++) pipe[k] <= pipe[k-1];
   end
   assign tri_rd_data = pipe[ML-1];

   // projector: busy while computing, done for dh cycles, then busy again for bh cycles
   always @(posedge clk_in) begin
      if (rst_in) t <= 0;
      else if (proj_start) begin
         t  <= 1;
         pv <= proj_verts_in;
      end else if (t > 0) t <= (t >= lt[pv[5:0]] + dh + bh - 1) ? 0 : t + 1;
   end
   assign proj_done      = t > 0 && t >= lt[pv[5:0]] && t < lt[pv[5:0]] + dh;
   assign proj_busy      = t > 0 && !proj_done;
   assign proj_valid     = proj_done && vl[pv[5:0]];
   assign proj_status    = 2'(st_a[pv[5:0]]);
   assign proj_verts_out = {~pv[3*CW-1:0], pv};

   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (proj_start) begin
            sidx_q.push_back(int'(proj_verts_in[IW-1:0]));
            n_start++;
         end
         if (frame_done) n_done++;
         if (out_valid && out_ready) got_q.push_back(out_tri);
      end
   end

   function automatic void set_plan(input int i, input int s, input bit v, input int l);
      st_a[i] = s;
      vl[i]   = v;
      lt[i]   = l;
   endfunction

   function automatic void model(input int n);
      exp_q.delete();
      exp_d = 0;
      exp_c = 0;
      exp_e = 0;
      for (int i = 0; i < n; i++) begin
         if (vl[i]) begin
            exp_q.push_back({~mem[i][3*CW-1:0], mem[i]});
            exp_d++;
         end else if (st_a[i] == 1) exp_c++;
         else exp_e++;
      end
   endfunction

   function automatic void clear_mon();
      got_q.delete();
      sidx_q.delete();
   endfunction

   task automatic run_frame(input int n, output bit to);
      @(negedge clk_in);
      num_tris = IW'(n);
      frame_start = 1'b1;
      @(negedge clk_in);
      frame_start = 1'b0;
      num_tris = IW'($urandom);
      to = 1'b1;
      for (int c = 0; c < 5000; c++) begin
         if (frame_done) begin
            to = 1'b0;
            break;
         end
         @(negedge clk_in);
      end
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      n_cmp++;
      if ({tri_addr, proj_start, out_valid, busy, frame_done, tris_drawn, tris_culled, tris_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: addr=%0d start=%b valid=%b busy=%b done=%b cnt=%0d/%0d/%0d, required all 0",
                  tri_addr, proj_start, out_valid, busy, frame_done, tris_drawn, tris_culled, tris_err);
      end
      n_cmp++;
      if (out_tri !== '0 || proj_verts_in !== '0) begin
         n_fail++;
         $display("FAIL reset_data: out_tri_nonzero=%b verts_nonzero=%b, required 0/0", out_tri !== '0, proj_verts_in !== '0);
      end
   endtask

   task automatic test_valid_all();
      bit to;
      int bad;
      for (int i = 0; i < 3; i++) set_plan(i, 0, 1'b1, $urandom_range(1, 5));
      dh = 1;
      bh = 0;
      out_ready = 1'b1;
      model(3);
      clear_mon();
      begin
         int d0 = n_done;
         run_frame(3, to);
         n_cmp++;
         if (to) begin n_fail++; $display("FAIL valid_all_timeout: frame_done not seen, required within bound"); end
         n_cmp++;
         bad = 0;
         if (sidx_q.size() != 3) bad++;
         else foreach (sidx_q[i]) if (sidx_q[i] != i) bad++;
         if (bad != 0) begin n_fail++; $display("FAIL valid_all_addr: %0d starts with %0d out of order, required 3 in order 0,1,2", sidx_q.size(), bad); end
         n_cmp++;
         bad = 0;
         if (got_q.size() != exp_q.size()) bad++;
         else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
         if (bad != 0) begin n_fail++; $display("FAIL valid_all_beats: %0d beats (%0d wrong), required %0d", got_q.size(), bad, exp_q.size()); end
         n_cmp++;
         if (tris_drawn !== IW'(exp_d) || tris_culled !== '0 || tris_err !== '0 || n_done - d0 != 1) begin
            n_fail++;
            $display("FAIL valid_all_counts: d/c/e=%0d/%0d/%0d done_pulses=%0d, required %0d/0/0 and 1", tris_drawn, tris_culled, tris_err, n_done - d0, exp_d);
         end
      end
   endtask

   task automatic test_empty_frame();
      int s0 = n_start;
      int d0 = n_done;
      @(negedge clk_in);
      num_tris = '0;
      frame_start = 1'b1;
      @(negedge clk_in);
      frame_start = 1'b0;
      n_cmp++;
      if (frame_done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL empty_c1: done=%b busy=%b, required 0/1", frame_done, busy); end
      @(negedge clk_in);
      n_cmp++;
      if (frame_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL empty_c2: done=%b busy=%b, required 1/0", frame_done, busy); end
      repeat (3) @(negedge clk_in);
      n_cmp++;
      if (n_start != s0 || n_done - d0 != 1 || {tris_drawn, tris_culled, tris_err} !== '0) begin
         n_fail++;
         $display("FAIL empty_after: starts=%0d done_pulses=%0d cnt=%0d/%0d/%0d, required 0, 1, 0/0/0",
                  n_start - s0, n_done - d0, tris_drawn, tris_culled, tris_err);
      end
   endtask

   task automatic test_mixed_status();
      bit to;
      int bad;
      set_plan(0, 0, 1'b1, 2);
      set_plan(1, 1, 1'b0, 3);
      set_plan(2, 2, 1'b0, 1);
      set_plan(3, 0, 1'b1, 4);
      dh = 1;
      bh = 0;
      out_ready = 1'b1;
      model(4);
      clear_mon();
      run_frame(4, to);
      n_cmp++;
      if (to) begin n_fail++; $display("FAIL mixed_timeout: frame_done not seen, required within bound"); end
      n_cmp++;
      if (tris_drawn !== IW'(2) || tris_culled !== IW'(1) || tris_err !== IW'(1)) begin
         n_fail++;
         $display("FAIL mixed_counts: d/c/e=%0d/%0d/%0d, required 2/1/1", tris_drawn, tris_culled, tris_err);
      end
      n_cmp++;
      bad = 0;
      if (got_q.size() != 2) bad++;
      else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      if (bad != 0) begin n_fail++; $display("FAIL mixed_beats: %0d beats (%0d wrong), required triangles 0 and 3", got_q.size(), bad); end
   endtask

   task automatic test_done_hold();
      bit to;
      int bad;
      int s0;
      for (int i = 0; i < 5; i++) begin
         int r = $urandom_range(0, 3);
         set_plan(i, r, r == 0, $urandom_range(1, 4));
      end
      dh = 2;
      bh = 2;
      out_ready = 1'b1;
      model(5);
      clear_mon();
      s0 = n_start;
      run_frame(5, to);
      n_cmp++;
      if (to || n_start - s0 != 5) begin n_fail++; $display("FAIL hold_starts: timeout=%b starts=%0d, required 0 and 5", to, n_start - s0); end
      n_cmp++;
      if (tris_drawn !== IW'(exp_d) || tris_culled !== IW'(exp_c) || tris_err !== IW'(exp_e)) begin
         n_fail++;
         $display("FAIL hold_counts: d/c/e=%0d/%0d/%0d, required %0d/%0d/%0d", tris_drawn, tris_culled, tris_err, exp_d, exp_c, exp_e);
      end
      n_cmp++;
      bad = 0;
      if (got_q.size() != exp_q.size()) bad++;
      else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      if (bad != 0) begin n_fail++; $display("FAIL hold_beats: %0d beats (%0d wrong), required %0d", got_q.size(), bad, exp_q.size()); end
      dh = 1;
      bh = 0;
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] hold;
      logic [IW-1:0] a;
      int s_init, s0, bad, c;
      bit to;
      set_plan(0, 0, 1'b1, 2);
      set_plan(1, 0, 1'b1, 2);
      model(2);
      clear_mon();
      out_ready = 1'b0;
      s_init = n_start;
      @(negedge clk_in);
      num_tris = IW'(2);
      frame_start = 1'b1;
      @(negedge clk_in);
      frame_start = 1'b0;
      for (c = 0; c < 100 && !out_valid; c++) @(negedge clk_in);
      n_cmp++;
      if (!out_valid) begin n_fail++; $display("FAIL bp_valid: out_valid=%b, required 1 within bound", out_valid); end
      hold = out_tri;
      a = tri_addr;
      s0 = n_start;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_in);
         if (!out_valid || out_tri !== hold || tri_addr !== a) bad++;
         frame_start = (k == 3);
         num_tris = IW'(7);
      end
      frame_start = 1'b0;
      n_cmp++;
      if (bad != 0 || n_start != s0) begin n_fail++; $display("FAIL bp_stable: %0d unstable cycles, %0d new starts, required 0/0", bad, n_start - s0); end
      @(posedge clk_in);
      #1 out_ready = 1'b1;
      to = 1'b1;
      for (c = 0; c < 500; c++) begin
         @(negedge clk_in);
         if (frame_done) begin to = 1'b0; break; end
      end
      repeat (5) @(negedge clk_in);
      n_cmp++;
      if (to || busy !== 1'b0 || n_start - s_init != 2 || tris_drawn !== IW'(2)) begin
         n_fail++;
         $display("FAIL bp_end: timeout=%b busy=%b starts=%0d drawn=%0d, required 0/0/2/2", to, busy, n_start - s_init, tris_drawn);
      end
      n_cmp++;
      bad = 0;
      if (got_q.size() != exp_q.size()) bad++;
      else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      if (bad != 0) begin n_fail++; $display("FAIL bp_beats: %0d beats (%0d wrong), required %0d", got_q.size(), bad, exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      bit to;
      int c, d0, bad;
      for (int i = 0; i < 5; i++) set_plan(i, 0, 1'b1, 20);
      out_ready = 1'b1;
      @(negedge clk_in);
      num_tris = IW'(5);
      frame_start = 1'b1;
      @(negedge clk_in);
      frame_start = 1'b0;
      for (c = 0; c < 100 && !proj_start; c++) @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      n_cmp++;
      if ({tri_addr, proj_start, out_valid, busy, frame_done, tris_drawn, tris_culled, tris_err} !== '0 ||
          out_tri !== '0 || proj_verts_in !== '0) begin
         n_fail++;
         $display("FAIL midreset_vals: addr=%0d start=%b valid=%b busy=%b done=%b verts_nonzero=%b, required reset values",
                  tri_addr, proj_start, out_valid, busy, frame_done, proj_verts_in !== '0);
      end
      rst_in = 1'b0;
      d0 = n_done;
      repeat (8) @(negedge clk_in);
      n_cmp++;
      if (n_done != d0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_nodone: done_pulses=%0d busy=%b, required 0/0", n_done - d0, busy); end
      set_plan(0, 0, 1'b1, 1);
      set_plan(1, 0, 1'b1, 1);
      model(2);
      clear_mon();
      run_frame(2, to);
      n_cmp++;
      bad = 0;
      if (sidx_q.size() != 2) bad++;
      else foreach (sidx_q[i]) if (sidx_q[i] != i) bad++;
      foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
      if (to || bad != 0 || tris_drawn !== IW'(2)) begin
         n_fail++;
         $display("FAIL midreset_restart: timeout=%b bad=%0d drawn=%0d, required 0/0/2", to, bad, tris_drawn);
      end
   endtask

   task automatic test_random_frames();
      bit to, fin;
      int bad, n, s0;
      for (int f = 0; f < 4; f++) begin
         n = $urandom_range(6, 20);
         for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 3);
            set_plan(i, r, r == 0, $urandom_range(1, 6));
         end
         dh = $urandom_range(1, 2);
         bh = $urandom_range(0, 2);
         model(n);
         clear_mon();
         s0 = n_start;
         fin = 1'b0;
         fork
            begin run_frame(n, to); fin = 1'b1; end
            while (!fin) begin @(posedge clk_in); #1 out_ready = 1'($urandom); end
         join
         @(posedge clk_in);
         #1 out_ready = 1'b1;
         n_cmp++;
         if (to || n_start - s0 != n) begin n_fail++; $display("FAIL rand_starts f%0d: timeout=%b starts=%0d, required 0/%0d", f, to, n_start - s0, n); end
         n_cmp++;
         if (tris_drawn !== IW'(exp_d) || tris_culled !== IW'(exp_c) || tris_err !== IW'(exp_e)) begin
            n_fail++;
            $display("FAIL rand_counts f%0d: d/c/e=%0d/%0d/%0d, required %0d/%0d/%0d", f, tris_drawn, tris_culled, tris_err, exp_d, exp_c, exp_e);
         end
         n_cmp++;
         bad = 0;
         if (got_q.size() != exp_q.size()) bad++;
         else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
         if (bad != 0) begin n_fail++; $display("FAIL rand_beats f%0d: %0d beats (%0d wrong), required %0d", f, got_q.size(), bad, exp_q.size()); end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         for (int w = 0; w < 9; w++) mem[i][w*CW +: CW] = $urandom;
         mem[i][IW-1:0] = IW'(i);
         set_plan(i, 0, 1'b1, 1);
      end
      test_reset();
      test_valid_all();
      test_empty_frame();
      test_mixed_status();
      test_done_hold();
      test_backpressure();
      test_reset_mid();
      test_random_frames();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/triangle_scheduler.md
Name: triangle_scheduler

Overview:
- Frame-level sequencer for the triangle projection unit.
- On frame_start it walks a triangle BRAM from index 0 to num_tris-1 and feeds each triangle's three vertices to the projector. It issues one start per triangle and waits for its done.
- Valid projected triangles are forwarded to the rasterizer over a valid/ready handshake. Discarded triangles (clipped or divide error) are counted, not forwarded.
- Sits between the scene memory and the rasterizer; the matrices go straight to the projector and are not routed through this block.

Parameters:
- COORD_WIDTH, 32, width of one Q(CW/2).(CW/2) signed coordinate
- IDX_WIDTH, 12, width of triangle index and of the statistics counters
- MEM_LATENCY, 2, BRAM read latency in cycles from tri_addr to tri_rd_data valid (>=1)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse; begins a frame pass
- num_tris  in  IDX_WIDTH  triangle count; sampled on an accepted frame_start
- tri_addr  out  IDX_WIDTH  BRAM read address
- tri_rd_data  in  9*COORD_WIDTH  three vertices {z,y,x} x3, vertex 0 in the LSBs
- proj_verts_in  out  9*COORD_WIDTH  triangle held to the projector
- proj_start  out  1  one-cycle start pulse to the projector
- proj_busy  in  1  projector busy
- proj_done  in  1  projector done
- proj_valid  in  1  projector result valid
- proj_status  in  2  0 = ok, 1 = clipped, 2 = divide error
- proj_verts_out  in  12*COORD_WIDTH  projected {1/w,z,y,x} x3
- out_tri  out  12*COORD_WIDTH  triangle to the rasterizer
- out_valid  out  1  out_tri valid
- out_ready  in  1  rasterizer accepts
- busy  out  1  frame pass in progress
- frame_done  out  1  one-cycle pulse at the end of the pass
- tris_drawn  out  IDX_WIDTH  triangles forwarded in this pass
- tris_culled  out  IDX_WIDTH  triangles with status 1
- tris_err  out  IDX_WIDTH  triangles with status 2 or any other non-zero status

Behaviour:
- Reset values: tri_addr = 0, proj_start = 0, out_valid = 0, out_tri = 0, proj_verts_in = 0, busy = 0, frame_done = 0, all counters 0, state IDLE.
- Reset has priority over every other input in every state. A reset mid-pass drops the pass with no frame_done. rst_in also resets the projector.

State machine:
- IDLE:
  - On frame_start: latch num_tris, clear all counters, set idx = 0, busy = 1.
  - If num_tris == 0, go to FINISH; otherwise go to FETCH.
  - frame_start in any other state is ignored.
- FETCH:
  - Drive tri_addr = idx and wait MEM_LATENCY cycles.
  - Then latch tri_rd_data into proj_verts_in and go to ARM.
  - proj_verts_in stays stable until the next FETCH completes.
- ARM:
  - Wait until proj_busy == 0 and proj_done == 0. This absorbs the projector's multi-cycle done.
  - Then assert proj_start for exactly one cycle and go to WAIT.
- WAIT:
  - Ignore proj_done in the first cycle after proj_start.
  - On proj_done with proj_valid = 1: latch proj_verts_out into out_tri, set out_valid = 1, go to EMIT.
  - On proj_done with proj_valid = 0: increment tris_culled if proj_status == 1, otherwise increment tris_err; go to NEXT.
  - There is no timeout.
- EMIT:
  - out_valid and out_tri are held stable until out_ready is high on a rising edge.
  - On that edge: out_valid = 0, tris_drawn++, go to NEXT.
  - out_ready already high on entry completes the transfer in one cycle.
- NEXT:
  - idx++.
  - If the new idx == latched num_tris, go to FINISH; otherwise go to FETCH.
- FINISH: frame_done = 1 for one cycle, busy = 0, go to IDLE.
- Counters are saturating at 2^IDX_WIDTH-1 and hold their values after FINISH until the next accepted frame_start.
- num_tris changing mid-pass has no effect.
- Minimum cycles per culled triangle = MEM_LATENCY + 4, plus projector latency.

Test Plan:
1. Reset, then frame_start with num_tris = 0 -> frame_done pulses 2 cycles later; counters 0; proj_start never asserted.
2. num_tris = 3, projector model returns valid for all, out_ready held high -> tri_addr visits 0, 1, 2; three out_valid beats with matching out_tri; tris_drawn = 3; single frame_done.
3. num_tris = 4, statuses ok, 1, 2, ok -> tris_drawn = 2, tris_culled = 1, tris_err = 1; out_tri carries only triangles 0 and 3.
4. Projector model holds done high for 2 cycles and busy after done -> exactly one proj_start per triangle; no double counting.
5. out_ready low for 10 cycles during EMIT -> out_valid and out_tri stable for all 10 cycles; no FETCH until acceptance; frame_start during the pass is ignored.
6. rst_in asserted in WAIT with num_tris = 5 -> next cycle all outputs at reset values, no frame_done; a new frame_start restarts at idx 0.
